// File: rtl/lif_pkg.sv
// ============================================================================
// Module  : lif_pkg
// Purpose : Shared constants and FSM state type for the lif rate display.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package lif_pkg;

   localparam logic [6:0] SEG_DASH  = 7'b1000000;
   localparam logic [6:0] SEG_BLANK = 7'b0000000;
   localparam logic [6:0] SEG_F     = 7'b1110001;

   // Segment order is {g,f,e,d,c,b,a}, active-high; entry 15 is listed first.
   localparam logic [15:0][6:0] SEG_HEX_TABLE = {
      7'b1110001,  // F
      7'b1111001,  // E
      7'b1011110,  // d
      7'b0111001,  // C
      7'b1111100,  // b
      7'b1110111,  // A
      7'b1101111,  // 9
      7'b1111111,  // 8
      7'b0000111,  // 7
      7'b1111101,  // 6
      7'b1101101,  // 5
      7'b1100110,  // 4
      7'b1001111,  // 3
      7'b1011011,  // 2
      7'b0000110,  // 1
      7'b0111111   // 0
   };

   typedef logic [0:0] lif_state_t;
   localparam lif_state_t S_INIT = 1'b0;
   localparam lif_state_t S_RUN  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/seg7_hex.sv
// ============================================================================
// Module  : seg7_hex
// Purpose : Combinational 4-bit hex digit to 7-segment {g,f,e,d,c,b,a} decoder.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module seg7_hex
   import lif_pkg::*;
(
   input  logic [3:0] digit,
   output logic [6:0] seg
);

   assign seg = SEG_HEX_TABLE[digit];

endmodule

`default_nettype wire

// File: rtl/lif_rate_display.sv
// ============================================================================
// Module  : lif_rate_display
// Purpose : Counts lif spikes over a 2^WINDOW_LOG2 enabled-cycle window and
//           shows the saturated count as a hex digit on a 7-segment display.
//           Define LIF_RATE_BLINK_EN to blink F on overflow instead of steady F.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module lif_rate_display
   import lif_pkg::*;
#(
   parameter int WINDOW_LOG2 = 10,
   parameter int BLINK_LOG2  = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic       spike,
   output logic [6:0] segments,
   output logic [3:0] rate,
   output logic       rate_valid,
   output logic       overflow
);

   generate
      if (WINDOW_LOG2 < 2 || WINDOW_LOG2 > 16 || BLINK_LOG2 > 16) begin : g_param_check
         $error("lif_rate_display: WINDOW_LOG2 or BLINK_LOG2 out of range");
      end
   endgenerate

   localparam logic [WINDOW_LOG2-1:0] c_win_last = {WINDOW_LOG2{1'b1}};
   localparam logic [WINDOW_LOG2-1:0] c_win_one  = WINDOW_LOG2'(1);

   logic [WINDOW_LOG2-1:0] r_win_cnt;
   logic [3:0]             r_spk_cnt;
   logic                   r_ovf_acc;
   lif_state_t             r_state;
   logic [3:0]             r_rate;
   logic                   r_overflow;
   logic                   r_rate_valid;
   logic [6:0]             r_segments;

   logic                   w_close;
   logic                   w_spk_sat;
   logic [3:0]             w_spk_final;
   logic                   w_ovf_final;
   lif_state_t             w_state_nxt;
   logic [3:0]             w_rate_nxt;
   logic                   w_ovf_nxt;
   logic [6:0]             w_hex_seg;
   logic [6:0]             w_ovf_seg;
   logic [6:0]             w_seg_nxt;

   assign w_close   = ena && (r_win_cnt == c_win_last);
   assign w_spk_sat = (r_spk_cnt == 4'hF);

   // Count including this cycle's spike, so a spike on the closing cycle lands in the closing window.
   assign w_spk_final = (spike && !w_spk_sat) ? (r_spk_cnt + 4'd1) : r_spk_cnt;
   assign w_ovf_final = r_ovf_acc | (spike & w_spk_sat);

   always_comb begin
      w_state_nxt = r_state;
      w_rate_nxt  = r_rate;
      w_ovf_nxt   = r_overflow;
      if (w_close) begin
         w_state_nxt = S_RUN;
         w_rate_nxt  = w_spk_final;
         w_ovf_nxt   = w_ovf_final;
      end
   end

   seg7_hex u_seg7_hex (
      .digit (w_rate_nxt),
      .seg   (w_hex_seg)
   );

`ifdef LIF_RATE_BLINK_EN
   // The MSB of the blink counter is the display phase; clearing it at each latch shows F first.
   logic [BLINK_LOG2:0] r_blink_cnt;
   logic [BLINK_LOG2:0] w_blink_nxt;

   assign w_blink_nxt = w_close ? '0 : (r_blink_cnt + (BLINK_LOG2+1)'(1));
   assign w_ovf_seg   = w_blink_nxt[BLINK_LOG2] ? SEG_BLANK : SEG_F;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_blink_cnt <= '0;
      end else if (ena) begin
         r_blink_cnt <= w_blink_nxt;
      end
   end
`else
   assign w_ovf_seg = SEG_F;
`endif

   assign w_seg_nxt = (w_state_nxt == S_INIT) ? SEG_DASH :
                      w_ovf_nxt                ? w_ovf_seg :
                                                 w_hex_seg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_win_cnt    <= '0;
         r_spk_cnt    <= 4'd0;
         r_ovf_acc    <= 1'b0;
         r_state      <= S_INIT;
         r_rate       <= 4'd0;
         r_overflow   <= 1'b0;
         r_rate_valid <= 1'b0;
         r_segments   <= SEG_DASH;
      end else if (ena) begin
         r_win_cnt  <= r_win_cnt + c_win_one;
         r_state    <= w_state_nxt;
         r_rate     <= w_rate_nxt;
         r_overflow <= w_ovf_nxt;
         r_segments <= w_seg_nxt;
         if (w_close) begin
            r_spk_cnt    <= 4'd0;
            r_ovf_acc    <= 1'b0;
            r_rate_valid <= 1'b1;
         end else begin
            r_spk_cnt    <= w_spk_final;
            r_ovf_acc    <= w_ovf_final;
            r_rate_valid <= 1'b0;
         end
      end else begin
         r_rate_valid <= 1'b0;
      end
   end

   assign segments   = r_segments;
   assign rate       = r_rate;
   assign rate_valid = r_rate_valid;
   assign overflow   = r_overflow;

endmodule

`default_nettype wire
